// File: rtl/neural_target_encoder_if.sv
// neural_target_encoder_if
// Stream bundle between a seven-segment code source and the encoder, and
// between the encoder and the downstream consumer of Q4.12 target words.
//   seg_in/in_valid/in_ready           : input code handshake
//   out_data/out_idx/out_valid/out_ready/out_last/out_err : output word stream
// Modports:
//   slave  - the encoder side (accepts codes, produces words)
//   master - the environment side (drives codes, consumes words)
interface neural_target_encoder_if;
    logic [7:0]  seg_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_err;

    modport slave (
        input  seg_in, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_valid, out_last, out_err
    );

    modport master (
        output seg_in, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_valid, out_last, out_err
    );
endinterface

// File: rtl/neural_target_encoder.sv
// neural_target_encoder
// Converts one seven-segment code (dp,g,f,e,d,c,b,a) into a one-hot frame of
// ten Q4.12 target words, one per digit node 0..9. An unrecognised code still
// yields a full frame, all OFF_VAL, flagged with out_err on every word.
// Ports:
//   clk       - clock, rising edge
//   n_rst     - synchronous active-low reset
//   bus       - neural_target_encoder_if.slave (code input + word stream)
//   err_count - 8-bit saturating count of accepted invalid codes, present
//               only when NEURAL_TARGET_ERRCNT_EN is defined
// Parameters:
//   ON_VAL    - word for the selected node (default 1.0 in Q4.12)
//   OFF_VAL   - word for every other node
// Configuration macro: NEURAL_TARGET_ERRCNT_EN
module neural_target_encoder #(
    parameter logic [15:0] ON_VAL  = 16'h1000,
    parameter logic [15:0] OFF_VAL = 16'h0000
) (
    input  logic clk,
    input  logic n_rst,
`ifdef NEURAL_TARGET_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    neural_target_encoder_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [3:0]  digit;
    logic        digit_ok;
    logic [3:0]  dec_digit;
    logic        dec_ok;
    logic        accept;
    logic        xfer;

    // Only the exact ten segment patterns are digits; dp set is always invalid.
    always_comb begin
        dec_digit = '0;
        dec_ok    = 1'b1;
        case (bus.seg_in)
            8'h3F: dec_digit = 4'd0;
            8'h06: dec_digit = 4'd1;
            8'h5B: dec_digit = 4'd2;
            8'h4F: dec_digit = 4'd3;
            8'h66: dec_digit = 4'd4;
            8'h6D: dec_digit = 4'd5;
            8'h7D: dec_digit = 4'd6;
            8'h07: dec_digit = 4'd7;
            8'h7F: dec_digit = 4'd8;
            8'h6F: dec_digit = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        bus.out_err   = 1'b0;
        accept        = 1'b0;
        xfer          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (bus.in_valid) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_idx   = cnt;
                bus.out_data  = (digit_ok && cnt == digit) ? ON_VAL : OFF_VAL;
                bus.out_last  = (cnt == 4'd9);
                bus.out_err   = ~digit_ok;
                xfer          = bus.out_ready;
                if (bus.out_ready && cnt == 4'd9) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            digit    <= '0;
            digit_ok <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                digit    <= dec_digit;
                digit_ok <= dec_ok;
                cnt      <= '0;
            end else if (xfer) begin
                // Wrap after node 9 so the counter is already 0 back in IDLE.
                cnt <= (cnt == 4'd9) ? '0 : cnt + 4'd1;
            end
        end
    end

`ifdef NEURAL_TARGET_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err_count <= '0;
        end else if (accept && !dec_ok && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    // No invalid-code counter in this build.
`endif

endmodule

// File: doc/neural_target_encoder.md
NEURAL_TARGET_ENCODER -- requirements
Module: neural_target_encoder

Interface
REQ-001 The block SHALL have parameter ON_VAL, default 16'h1000, the Q4.12 target word (1.0) for the selected digit node.
REQ-002 The block SHALL have parameter OFF_VAL, default 16'h0000, the Q4.12 target word for non-selected nodes.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  reset; synchronous and active-low.
REQ-005 seg_in  input  8  seven-segment code, bit order dp,g,f,e,d,c,b,a (bit7 = dp).
REQ-006 in_valid  input  1  seg_in is valid this cycle.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 out_data  output  16  target word for node out_idx, Q4.12 unsigned.
REQ-009 out_idx  output  4  node index of out_data, 0..9.
REQ-010 out_valid  output  1  out_data/out_idx/out_last/out_err are valid.
REQ-011 out_ready  input  1  downstream accepts the word this cycle.
REQ-012 out_last  output  1  high with the word for node 9.
REQ-013 out_err  output  1  high with every word of a frame produced from an invalid code.

Function
REQ-014 Decode: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9; any other 8-bit value, including any value with bit7 set, is invalid.
REQ-015 States: IDLE and SEND only.
REQ-016 IDLE: in_ready=1, out_valid=0; when in_valid=1, latch decoded digit and validity, clear word counter to 0, go to SEND.
REQ-017 SEND: in_ready=0, out_valid=1; in_valid is ignored.
REQ-018 Latency: code accepted at edge N gives out_valid=1 with out_idx=0 in the cycle after edge N.
REQ-019 In SEND, out_idx = word counter, and out_data = ON_VAL when out_idx equals the latched digit and the code was valid, else OFF_VAL.
REQ-020 Handshake: a word transfers on an edge where out_valid=1 and out_ready=1; the counter then increments.
REQ-021 Backpressure: while out_ready=0, out_data, out_idx, out_last and out_err SHALL hold unchanged.
REQ-022 out_last = 1 exactly when out_idx = 9; transfer of that word SHALL return the block to IDLE with in_ready=1 in the next cycle.
REQ-023 Invalid code: the frame SHALL still emit 10 words, all OFF_VAL, with out_err=1 on each.
REQ-024 Each frame SHALL contain exactly one ON_VAL word for a valid code and none for an invalid one; every frame SHALL be 10 words, idx 0..9 in order.
REQ-025 Minimum frame period with out_ready held high is 11 cycles: 1 IDLE accept plus 10 SEND words.

Reset
REQ-026 n_rst=0 at a rising edge SHALL force IDLE, counter 0, latched digit 0, latched-valid 0.
REQ-027 Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, out_err=0.
REQ-028 Reset mid-frame SHALL abandon the frame; no further words of it are emitted.

Configuration
REQ-029 Macro NEURAL_TARGET_ERRCNT_EN: when defined, the block SHALL add output err_count (8 bits), reset to 0.
REQ-030 With the macro defined, err_count SHALL increment by 1 on each accepted invalid code and saturate at 8'hFF.
REQ-031 Without the macro, err_count SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-032 Send seg_in=8'h5B with out_ready held 1 -> 10 words idx 0..9; idx 2 = 16'h1000, all others 16'h0000; out_last only on idx 9; in_ready=1 on the 11th cycle.
REQ-033 Send seg_in=8'h06, hold out_ready=0 for 5 cycles at idx 1 -> out_data holds 16'h1000 and out_idx holds 1 throughout; stream resumes in order.
REQ-034 Send seg_in=8'hBF (dp set) -> 10 words of 16'h0000 with out_err=1 on each; with NEURAL_TARGET_ERRCNT_EN, err_count 0->1.
REQ-035 Assert in_valid with 8'h6F while in SEND -> input ignored (in_ready=0); the current frame completes unchanged and no second frame starts without a new handshake.
REQ-036 Pull n_rst low at idx 4 of a frame -> next cycle out_valid=0, in_ready=1, out_idx=0; a following seg_in=8'h3F yields idx 0 = 16'h1000.
